// File: rtl/apb4_param_slave.sv
// APB4 slave backed by DEPTH x DATA_W storage with byte-lane write strobes,
// a programmable number of wait cycles per access and error response for
// out-of-range or misaligned addresses.
module apb4_param_slave #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WAIT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LSB_W  = $clog2(NB);
  localparam int unsigned CNT_W  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW1    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'((1 << LSB_W) - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = AW1'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [MEM_AW-1:0]   widx_q, widx_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic [MEM_AW-1:0]   idx_mem;
  logic                addr_err;

  // Word index and error decode of the current address
  always_comb begin
    idx      = paddr >> LSB_W;
    idx_mem  = MEM_AW'(idx);
    addr_err = ({1'b0, idx} >= DEPTH_LIM) || (|(paddr & LSB_MASK));
  end

  // Next-state, capture and storage-update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    widx_d   = widx_q;
    prdata_d = prdata_q;
    mem_d    = mem_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT);
          err_d   = addr_err;
          widx_d  = idx_mem;
          if (!pwrite) begin
            prdata_d = addr_err ? '0 : mem_q[idx_mem];
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            if (pwrite && !err_q) begin
              for (int unsigned i = 0; i < NB; i++) begin
                if (pstrb[i]) begin
                  mem_d[widx_q][i*8 +: 8] = pwdata[i*8 +: 8];
                end
              end
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture and storage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      widx_q   <= '0;
      prdata_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      widx_q   <= widx_d;
      prdata_q <= prdata_d;
      mem_q    <= mem_d;
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    pready  = (state_q == ACCESS) && (cnt_q == '0);
    pslverr = err_q && pready;
    prdata  = prdata_q;
  end

endmodule

// File: tb/tb_apb4_param_slave.sv
// Scoreboarded bench for apb4_param_slave: a WAIT=2 instance and a WAIT=0
// instance share the bus except for psel.
module tb_apb4_param_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel0 = 1'b0, psel1 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [9:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb4_param_slave #(.ADDR_W(10), .DATA_W(32), .DEPTH(64), .WAIT(2)) dut0 (
    .clk(clk), .reset(reset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb4_param_slave #(.ADDR_W(10), .DATA_W(32), .DEPTH(64), .WAIT(0)) dut1 (
    .clk(clk), .reset(reset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  typedef struct {
    int          w;
    bit          wr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    string       nm;
  } xfer_t;

  exp_t        sb[$];
  logic [31:0] mmem  [2][64];
  logic [31:0] mlast [2];

  task automatic model_reset;
    for (int w = 0; w < 2; w++) begin
      mlast[w] = '0;
      for (int i = 0; i < 64; i++) mmem[w][i] = '0;
    end
  endtask

  // Reference memory: computes what a transfer must return and updates itself
  task automatic model_push(input int w, input bit wr, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   idx;
    bit   er;
    idx = int'(a) / 4;
    er = (idx >= 64) || (a[1:0] != 2'b00);
    e.err = er;
    e.cycles = (w == 0) ? 3 : 1;
    if (wr) begin
      if (!er)
        for (int b = 0; b < 4; b++)
          if (s[b]) mmem[w][idx][b*8 +: 8] = d[b*8 +: 8];
      e.rdata = mlast[w];
    end else begin
      if (er) e.rdata = '0;
      else    e.rdata = mmem[w][idx];
      mlast[w] = e.rdata;
    end
    sb.push_back(e);
  endtask

  // One APB transfer; returns outputs seen in the cycle pready is high
  task automatic xfer(input int w, input bit wr, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int cy);
    @(negedge clk);
    psel0 = (w == 0); psel1 = (w == 1);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    cy = 1;
    while ((((w == 0) ? pready0 : pready1) !== 1'b1) && cy < 20) begin
      @(negedge clk);
      cy++;
    end
    rd = (w == 0) ? prdata0 : prdata1;
    er = (w == 0) ? pslverr0 : pslverr1;
  endtask

  task automatic idle;
    @(negedge clk);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL reset_pready0 got=%b exp=0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL reset_pslverr0 got=%b exp=0", pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL reset_prdata0 got=%h exp=00000000", prdata0); end
    checks++; if (pready1 !== 1'b0) begin failures++; $display("FAIL reset_pready1 got=%b exp=0", pready1); end
    checks++; if (prdata1 !== 32'h0) begin failures++; $display("FAIL reset_prdata1 got=%h exp=00000000", prdata1); end
  endtask

  task automatic test_write_read;
    xfer_t t[$]; exp_t e; logic [31:0] rd; logic er; int cy;
    t.push_back('{0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF, "wr04"});
    t.push_back('{0, 1'b0, 10'h004, 32'h0, 4'h0, "rd04"});
    t.push_back('{0, 1'b1, 10'h010, 32'h0, 4'hF, "wr10_other"});
    t.push_back('{0, 1'b1, 10'h0FC, 32'h89ABCDEF, 4'hF, "wr_top"});
    t.push_back('{0, 1'b0, 10'h0FC, 32'h0, 4'h0, "rd_top"});
    foreach (t[i]) begin
      model_push(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s);
      xfer(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s, rd, er, cy);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s prdata got=%h exp=%h", t[i].nm, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL %s pslverr got=%b exp=%b", t[i].nm, er, e.err); end
      checks++; if (cy != e.cycles) begin failures++; $display("FAIL %s access_cycles got=%0d exp=%0d", t[i].nm, cy, e.cycles); end
      if (t[i].nm == "rd04") begin
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd04_literal prdata got=%h exp=deadbeef", rd); end
      end
    end
    idle();
  endtask

  task automatic test_strobe;
    xfer_t t[$]; exp_t e; logic [31:0] rd; logic er; int cy;
    do_reset();
    t.push_back('{0, 1'b1, 10'h008, 32'h11223344, 4'h5, "wr08_strb5"});
    t.push_back('{0, 1'b0, 10'h008, 32'hFFFFFFFF, 4'hA, "rd08"});
    foreach (t[i]) begin
      model_push(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s);
      xfer(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s, rd, er, cy);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s prdata got=%h exp=%h", t[i].nm, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL %s pslverr got=%b exp=%b", t[i].nm, er, e.err); end
      checks++; if (cy != e.cycles) begin failures++; $display("FAIL %s access_cycles got=%0d exp=%0d", t[i].nm, cy, e.cycles); end
    end
    checks++; if (rd !== 32'h00220044) begin failures++; $display("FAIL rd08_literal prdata got=%h exp=00220044", rd); end
    idle();
  endtask

  task automatic test_errors;
    xfer_t t[$]; exp_t e; logic [31:0] rd; logic er; int cy;
    t.push_back('{0, 1'b0, 10'h100, 32'h0, 4'h0, "rd_oob"});
    t.push_back('{0, 1'b0, 10'h006, 32'h0, 4'h0, "rd_misalign"});
    t.push_back('{0, 1'b0, 10'h008, 32'h0, 4'h0, "rd08_again"});
    t.push_back('{0, 1'b1, 10'h100, 32'hCAFEBABE, 4'hF, "wr_oob"});
    t.push_back('{0, 1'b1, 10'h005, 32'hFFFFFFFF, 4'hF, "wr_misalign"});
    t.push_back('{0, 1'b0, 10'h000, 32'h0, 4'h0, "rd00_after_err"});
    t.push_back('{0, 1'b0, 10'h004, 32'h0, 4'h0, "rd04_after_err"});
    foreach (t[i]) begin
      model_push(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s);
      xfer(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s, rd, er, cy);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s prdata got=%h exp=%h", t[i].nm, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL %s pslverr got=%b exp=%b", t[i].nm, er, e.err); end
      checks++; if (cy != e.cycles) begin failures++; $display("FAIL %s access_cycles got=%0d exp=%0d", t[i].nm, cy, e.cycles); end
    end
    idle();
    checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL pslverr_idle got=%b exp=0", pslverr0); end
  endtask

  task automatic test_idle_penable;
    exp_t e; logic [31:0] rd; logic er; int cy;
    @(negedge clk);
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL idle_penable_pready got=%b exp=0", pready0); end
    end
    idle();
    model_push(0, 1'b0, 10'h020, 32'h0, 4'h0);
    xfer(0, 1'b0, 10'h020, 32'h0, 4'h0, rd, er, cy);
    e = sb.pop_front();
    checks++; if (rd !== e.rdata) begin failures++; $display("FAIL rd20_noop prdata got=%h exp=%h", rd, e.rdata); end
    checks++; if (cy != e.cycles) begin failures++; $display("FAIL rd20_noop access_cycles got=%0d exp=%0d", cy, e.cycles); end
    idle();
  endtask

  task automatic test_abort;
    exp_t e; logic [31:0] rd; logic er; int cy;
    @(negedge clk);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h010; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL abort_pready got=%b exp=0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL abort_pslverr got=%b exp=0", pslverr0); end
    model_push(0, 1'b0, 10'h010, 32'h0, 4'h0);
    xfer(0, 1'b0, 10'h010, 32'h0, 4'h0, rd, er, cy);
    e = sb.pop_front();
    checks++; if (rd !== e.rdata) begin failures++; $display("FAIL abort_rd10 prdata got=%h exp=%h", rd, e.rdata); end
    checks++; if (er !== e.err) begin failures++; $display("FAIL abort_rd10 pslverr got=%b exp=%b", er, e.err); end
    checks++; if (cy != e.cycles) begin failures++; $display("FAIL abort_rd10 access_cycles got=%0d exp=%0d", cy, e.cycles); end
    idle();
  endtask

  task automatic test_reset_mid_write;
    xfer_t t[$]; exp_t e; logic [31:0] rd; logic er; int cy;
    t.push_back('{0, 1'b1, 10'h00C, 32'h12345678, 4'hF, "wr0c_pre"});
    t.push_back('{0, 1'b0, 10'h00C, 32'h0, 4'h0, "rd0c_pre"});
    foreach (t[i]) begin
      model_push(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s);
      xfer(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s, rd, er, cy);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s prdata got=%h exp=%h", t[i].nm, rd, e.rdata); end
    end
    @(negedge clk);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h00C; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL midreset_pready got=%b exp=0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL midreset_pslverr got=%b exp=0", pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL midreset_prdata got=%h exp=00000000", prdata0); end
    reset = 1'b0; psel0 = 1'b0; penable = 1'b0;
    model_reset();
    model_push(0, 1'b0, 10'h00C, 32'h0, 4'h0);
    xfer(0, 1'b0, 10'h00C, 32'h0, 4'h0, rd, er, cy);
    e = sb.pop_front();
    checks++; if (rd !== e.rdata) begin failures++; $display("FAIL midreset_rd0c prdata got=%h exp=%h", rd, e.rdata); end
    checks++; if (cy != e.cycles) begin failures++; $display("FAIL midreset_rd0c access_cycles got=%0d exp=%0d", cy, e.cycles); end
    idle();
  endtask

  task automatic test_back_to_back;
    xfer_t t[$]; exp_t e; logic [31:0] rd; logic er; int cy;
    t.push_back('{1, 1'b1, 10'h000, 32'h01020304, 4'hF, "b2b_wr0"});
    t.push_back('{1, 1'b1, 10'h004, 32'hA0B0C0D0, 4'hF, "b2b_wr1"});
    t.push_back('{1, 1'b1, 10'h008, 32'h55AA55AA, 4'hF, "b2b_wr2"});
    t.push_back('{1, 1'b1, 10'h0FC, 32'hFEEDFACE, 4'hF, "b2b_wr3"});
    t.push_back('{1, 1'b0, 10'h000, 32'h0, 4'h0, "b2b_rd0"});
    t.push_back('{1, 1'b0, 10'h004, 32'h0, 4'h0, "b2b_rd1"});
    t.push_back('{1, 1'b0, 10'h008, 32'h0, 4'h0, "b2b_rd2"});
    t.push_back('{1, 1'b0, 10'h0FC, 32'h0, 4'h0, "b2b_rd3"});
    foreach (t[i]) begin
      model_push(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s);
      xfer(t[i].w, t[i].wr, t[i].a, t[i].d, t[i].s, rd, er, cy);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s prdata got=%h exp=%h", t[i].nm, rd, e.rdata); end
      checks++; if (er !== e.err) begin failures++; $display("FAIL %s pslverr got=%b exp=%b", t[i].nm, er, e.err); end
      checks++; if (cy != e.cycles) begin failures++; $display("FAIL %s access_cycles got=%0d exp=%0d", t[i].nm, cy, e.cycles); end
    end
    idle();
  endtask

  // Hard stop in case a wait escapes its cycle budget
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_idle_penable();
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb4_param_slave.md
APB4_PARAM_SLAVE -- requirements
Module: apb4_param_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning APB address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; legal values are 8, 16, 32 and 64.
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning number of DATA_W-bit storage words.
REQ-004 The block SHALL have parameter WAIT, default 1, meaning wait cycles inserted per access; legal range is 0..15.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port psel, input, 1 bit: slave select.
REQ-008 The block SHALL have port penable, input, 1 bit: access-phase strobe.
REQ-009 The block SHALL have port pwrite, input, 1 bit: 1 for write, 0 for read.
REQ-010 The block SHALL have port paddr, input, ADDR_W bits: byte address.
REQ-011 The block SHALL have port pwdata, input, DATA_W bits: write data.
REQ-012 The block SHALL have port pstrb, input, DATA_W/8 bits: byte-lane write strobes.
REQ-013 The block SHALL have port prdata, output, DATA_W bits: read data.
REQ-014 The block SHALL have port pready, output, 1 bit: transfer completion.
REQ-015 The block SHALL have port pslverr, output, 1 bit: transfer error, meaningful only while pready=1.

Function
REQ-016 The FSM SHALL have two states, IDLE and ACCESS, plus a wait counter cnt of width clog2(WAIT+1).
REQ-017 In IDLE, when psel=1 and penable=0 (setup), the FSM SHALL go to ACCESS, load cnt=WAIT and capture index, the error flag and read data.
REQ-018 Word index SHALL be paddr >> log2(DATA_W/8).
REQ-019 The error flag SHALL be set if index >= DEPTH or the low log2(DATA_W/8) bits of paddr are nonzero.
REQ-020 pready SHALL equal (state==ACCESS && cnt==0), decoded from registers only, so WAIT=0 gives zero-wait transfers.
REQ-021 In ACCESS, while cnt!=0 and psel=1 and penable=1, cnt SHALL decrement by 1 per cycle.
REQ-022 Completion SHALL occur when pready=1 and psel=1 and penable=1; the FSM then returns to IDLE.
REQ-023 Back-to-back transfers SHALL be supported: the setup cycle following a completion is accepted from IDLE, giving 2+WAIT cycles per transfer.
REQ-024 On a write completion with the error flag clear, each byte lane i with pstrb[i]=1 SHALL be written with pwdata lane i; lanes with pstrb[i]=0 SHALL be unchanged.
REQ-025 On a write completion with the error flag set, storage SHALL be unchanged.
REQ-026 Reads SHALL return mem[index], registered into prdata at the setup capture, so a write completed in the previous transfer is visible.
REQ-027 Error reads SHALL load prdata=0; pstrb SHALL be ignored on reads.
REQ-028 prdata SHALL hold its value between transfers and during writes.
REQ-029 pslverr SHALL equal the error flag AND pready; it is 0 at all other times.
REQ-030 If psel=0 while in ACCESS before completion (protocol abort), the FSM SHALL return to IDLE with no storage write and pready=0 on the next cycle.
REQ-031 penable=1 while in IDLE without a preceding setup cycle SHALL be ignored.

Reset
REQ-032 When reset=1 at a clock edge, state SHALL become IDLE, cnt=0, the error flag=0, prdata=0 and every storage word=0.
REQ-033 After that reset edge, pready=0 and pslverr=0.
REQ-034 Reset SHALL take priority over any transfer in progress; an interrupted write SHALL not modify storage.

Verification (DATA_W=32, DEPTH=64, WAIT=2)
REQ-035 Write 0xDEADBEEF to addr 0x04 with pstrb=0xF, then read 0x04 -> pready rises on the 3rd access cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-036 Write 0x11223344 with pstrb=0x5 to addr 0x08 after reset, then read -> prdata=0x00220044.
REQ-037 Read addr 0x100 when ADDR_W=10 (index 64) or addr 0x06 (misaligned) -> pslverr=1 with pready, prdata=0, storage unchanged.
REQ-038 Assert reset during the wait cycles of a write to 0x0C, then read 0x0C -> pready=0 the cycle after reset, read returns 0.
REQ-039 Drop psel mid-ACCESS, then issue a fresh read -> FSM returns to IDLE with no write, and the new transfer completes normally after 2 wait cycles.
REQ-040 Run 4 back-to-back writes with WAIT=0 -> each completes in exactly 2 cycles and all 4 read back correctly.
